// File: rtl/mux_stream_rr.sv
// N-channel stream multiplexer with a single registered output stage.
// Channel choice is either manual (sel_i) or round-robin from a rotating pointer.
module mux_stream_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mode_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_CH-1:0]        valid_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  output logic [NUM_CH-1:0]        ready_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [SEL_W-1:0]         ch_o,
  input  logic                     ready_i
);

  // Handshake: a beat moves on a side only when its valid and ready are both
  // high at a rising edge; the output register refills in the same edge it drains.

  localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [SEL_W-1:0]  ch_q,    ch_d;
  logic [SEL_W-1:0]  ptr_q,   ptr_d;

  logic              load_en;
  logic              man_hit;
  logic              rr_hit;
  logic [SEL_W-1:0]  rr_g;
  logic [SEL_W:0]    rr_cand;
  logic              grant_hit;
  logic [SEL_W-1:0]  grant_ch;
  logic [DATA_W-1:0] grant_data;
  logic              in_xfer;

  assign load_en = !valid_q || ready_i;

  // Out-of-range select values never grant.
  assign man_hit = ({1'b0, sel_i} < NUM_CH_W) && valid_i[sel_i];

  // Scan from the highest offset down so the closest valid channel to ptr wins.
  always_comb begin
    rr_hit  = 1'b0;
    rr_g    = '0;
    rr_cand = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      rr_cand = {1'b0, ptr_q} + (SEL_W+1)'(i);
      if (rr_cand >= NUM_CH_W) begin
        rr_cand = rr_cand - NUM_CH_W;
      end
      if (valid_i[rr_cand[SEL_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_g   = rr_cand[SEL_W-1:0];
      end
    end
  end

  assign grant_hit = mode_i ? rr_hit : man_hit;
  assign grant_ch  = mode_i ? rr_g   : sel_i;
  assign in_xfer   = grant_hit && load_en;

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_ch == SEL_W'(k)) begin
        grant_data = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (rst_ni && in_xfer) begin
      ready_o[grant_ch] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = grant_data;
      ch_d    = grant_ch;
      if (mode_i) begin
        ptr_d = (grant_ch == LAST_CH) ? '0 : grant_ch + SEL_W'(1);
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ch_o    = ch_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Bench for mux_stream_rr: directed vector table, fairness/sparse sequences,
// then randomized traffic against a queue-free behavioural model.
module tb_mux_stream_rr;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int SW  = 2;

  logic            clk_i;
  logic            rst_ni;
  logic            mode_i;
  logic [SW-1:0]   sel_i;
  logic [NCH-1:0]  valid_i;
  logic [NCH*DW-1:0] data_i;
  logic [NCH-1:0]  ready_o;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic [SW-1:0]   ch_o;
  logic            ready_i;

  mux_stream_rr #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .mode_i  (mode_i),
    .sel_i   (sel_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ch_o    (ch_o),
    .ready_i (ready_i)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic mode, input logic [SW-1:0] sel,
                       input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d, input logic rdy);
    rst_ni  = rst;
    mode_i  = mode;
    sel_i   = sel;
    valid_i = v;
    data_i  = d;
    ready_i = rdy;
  endtask

  // called at edge+1; leaves the bench at the next edge+1
  task automatic clock_step();
    @(posedge clk_i);
    #1;
  endtask

  // behavioural reference
  bit       m_valid;
  int       m_data;
  int       m_ch;
  int       m_ptr;

  function automatic int model_grant(input logic mode, input int sel, input logic [NCH-1:0] v, input int ptr);
    if (!mode) begin
      if (sel < NCH && ((v >> sel) & 4'b1) != 0) return sel;
      return -1;
    end
    for (int k = 0; k < NCH; k++) begin
      int c = (ptr + k) % NCH;
      if (((v >> c) & 4'b1) != 0) return c;
    end
    return -1;
  endfunction

  typedef struct {
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [NCH-1:0] valid;
    logic           rdy;
    logic [NCH-1:0] exp_ready;
    logic           exp_v;
    logic [DW-1:0]  exp_d;
    logic [SW-1:0]  exp_ch;
  } vec_t;

  vec_t vecs[17];
  logic [DW-1:0] exp_q[$];

  function automatic vec_t mk(input logic rst, input logic mode, input logic [SW-1:0] sel,
                              input logic [NCH-1:0] v, input logic rdy, input logic [NCH-1:0] er,
                              input logic ev, input logic [DW-1:0] ed, input logic [SW-1:0] ec);
    vec_t r;
    r.rst = rst; r.mode = mode; r.sel = sel; r.valid = v; r.rdy = rdy;
    r.exp_ready = er; r.exp_v = ev; r.exp_d = ed; r.exp_ch = ec;
    return r;
  endfunction

  localparam logic [NCH*DW-1:0] TD = 32'h44A5_2211;

  initial begin
    // ch0=11 ch1=22 ch2=A5 ch3=44
    vecs[0]  = mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0);
    vecs[1]  = mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0);
    vecs[2]  = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0);
    vecs[3]  = mk(1, 0, 2, 4'b0100, 1, 4'b0100, 1, 8'hA5, 2);
    vecs[4]  = mk(1, 0, 1, 4'b0100, 1, 4'b0000, 0, 8'hA5, 2);
    vecs[5]  = mk(1, 0, 1, 4'b0110, 0, 4'b0010, 1, 8'h22, 1);
    vecs[6]  = mk(1, 0, 2, 4'b0100, 0, 4'b0000, 1, 8'h22, 1);
    vecs[7]  = mk(1, 0, 2, 4'b0100, 0, 4'b0000, 1, 8'h22, 1);
    vecs[8]  = mk(1, 0, 2, 4'b0100, 0, 4'b0000, 1, 8'h22, 1);
    vecs[9]  = mk(1, 0, 2, 4'b0100, 1, 4'b0100, 1, 8'hA5, 2);
    vecs[10] = mk(1, 1, 0, 4'b1010, 1, 4'b0010, 1, 8'h22, 1);
    vecs[11] = mk(1, 1, 0, 4'b1010, 1, 4'b1000, 1, 8'h44, 3);
    vecs[12] = mk(1, 1, 0, 4'b1010, 1, 4'b0010, 1, 8'h22, 1);
    vecs[13] = mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0);
    vecs[14] = mk(1, 1, 0, 4'b1100, 1, 4'b0100, 1, 8'hA5, 2);
    vecs[15] = mk(1, 1, 0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3);
    vecs[16] = mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0);

    drive(0, 1, 0, 4'b1111, TD, 1);
    clock_step();

    // directed table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].valid, TD, vecs[i].rdy);
      #2;
      check($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(vecs[i].exp_ready));
      clock_step();
      check($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d data_o", i), 32'(data_o), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d ch_o", i), 32'(ch_o), 32'(vecs[i].exp_ch));
    end

    // fairness: all valid, data = channel index, 8 beats incl. wrap
    drive(0, 1, 0, 4'b1111, 32'h0302_0100, 1);
    clock_step();
    for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i % NCH));
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] e;
      drive(1, 1, 0, 4'b1111, 32'h0302_0100, 1);
      e = exp_q.pop_front();
      #2;
      check($sformatf("fair%0d ready_o", i), 32'(ready_o), 32'(1 << e));
      clock_step();
      check($sformatf("fair%0d ch_o", i), 32'(ch_o), 32'(e));
      check($sformatf("fair%0d data_o", i), 32'(data_o), 32'(e));
    end

    // sparse round-robin: channels 1 and 3 only (ptr is 0 after 8 fair beats)
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 4'b1010, TD, 1);
      #2;
      check($sformatf("sparse%0d ready_o", i), 32'(ready_o), (i % 2 == 0) ? 32'h2 : 32'h8);
      clock_step();
      check($sformatf("sparse%0d ch_o", i), 32'(ch_o), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // randomized traffic against the model
    drive(0, 1, 0, 4'b0, TD, 1);
    clock_step();
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
    for (int i = 0; i < 1500; i++) begin
      logic r_rst, r_mode, r_rdy;
      logic [SW-1:0] r_sel;
      logic [NCH-1:0] r_v;
      logic [NCH*DW-1:0] r_d;
      int g;
      logic [NCH-1:0] e_rdy;
      bit load_en;
      r_rst  = ($urandom_range(0, 49) != 0);
      r_mode = 1'($urandom_range(0, 1));
      r_sel  = SW'($urandom_range(0, NCH - 1));
      r_v    = NCH'($urandom_range(0, 15));
      r_rdy  = ($urandom_range(0, 3) != 0);
      r_d    = $urandom;
      drive(r_rst, r_mode, r_sel, r_v, r_d, r_rdy);
      g = model_grant(r_mode, int'(r_sel), r_v, m_ptr);
      load_en = !m_valid || r_rdy;
      e_rdy = (r_rst && g >= 0 && load_en) ? NCH'(1 << g) : '0;
      if (!r_rst) begin
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
      end else if (g >= 0 && load_en) begin
        m_valid = 1;
        m_data  = int'((r_d >> (g * DW)) & 32'hFF);
        m_ch    = g;
        if (r_mode) m_ptr = (g + 1) % NCH;
      end else if (m_valid && r_rdy) begin
        m_valid = 0;
      end
      #2;
      check("rand ready_o", 32'(ready_o), 32'(e_rdy));
      clock_step();
      check("rand valid_o", 32'(valid_o), 32'(m_valid));
      check("rand data_o", 32'(data_o), 32'(m_data));
      check("rand ch_o", 32'(ch_o), 32'(m_ch));
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
